// File: rtl/mem_access_unit_pkg.sv
// mau_pkg: shared types and helpers for mem_access_unit.
//   op_e     - 3-bit load/store opcode as presented on req_op
//   state_e  - access FSM states
//   is_store, is_misaligned - opcode classification helpers
package mau_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic is_store(op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  // Words need a 4-byte aligned address, halfwords 2-byte; bytes never fault.
  function automatic logic is_misaligned(op_e op, logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake towards the MEM stage plus
// the data-memory port.
//   slave  - view of the access unit (accepts requests, drives the memory)
//   master - view of the environment (pipeline stage and data memory)
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_we;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_we
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_we
  );

endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// mau_byte_lane: combinational lane steering for the access unit.
//   op_i    - latched opcode
//   off_i   - byte offset within the word (addr[1:0])
//   word_i  - memory word as read
//   wdata_i - low halfword of the store data
//   load_o  - selected lane, sign/zero-extended (full word for LW)
//   merge_o - word_i with the SH/SB target lane replaced by store data
module mau_byte_lane
  import mau_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    load_o = word_i;
    case (op_i)
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'h0000, half_sel};
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'h000000, byte_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (op_i)
      OP_SH:   merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
      OP_SB:   merge_o[{off_i, 3'b000} +: 8]      = wdata_i[7:0];
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the word-wide data memory.
// One load/store per request handshake; sub-word stores use read-modify-write;
// misaligned accesses answer with rsp_err and never touch memory.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - request/response handshake and data-memory port (slave view)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;
  logic              err_q;

  op_e         req_op;
  logic        req_mis;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  // Address bits above the memory word range wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign req_op  = op_e'(bus.req_op);
  assign req_mis = is_misaligned(req_op, bus.req_addr[1:0]);

  mau_byte_lane u_lane (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .word_i  (bus.dm_rdata),
    .wdata_i (wdata_q[15:0]),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = req_mis ? ST_RESP : ST_EXEC;
      ST_EXEC:  state_d = (op_q inside {OP_SH, OP_SB}) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: dm_we depends only on registers so it is steady across the
  // falling edge at which the memory writes.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_wdata  = wdata_q;
    case (state_q)
      ST_IDLE:  bus.req_ready = 1'b1;
      ST_EXEC:  bus.dm_we     = (op_q == OP_SW);
      ST_WRITE: begin
        bus.dm_we    = 1'b1;
        bus.dm_wdata = merge_q;
      end
      ST_RESP:  bus.rsp_valid = 1'b1;
      default:  bus.req_ready = 1'b0;
    endcase
  end

  assign bus.dm_addr   = addr_q[ADDR_W+1:2];
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Request latch, load result and RMW merge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= req_op;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_mis;
          end
        end
        ST_EXEC: begin
          if (!is_store(op_q))                rdata_q <= lane_load;
          if (op_q inside {OP_SH, OP_SB})     merge_q <= lane_merge;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int unsigned widx;
    logic [31:0] word;
    int          acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  function automatic logic [31:0] init_word(int unsigned i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Data memory: asynchronous read, write on the falling edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (bus.dm_we === 1'b1) mem[bus.dm_addr] = bus.dm_wdata;
    end
  end
  assign bus.dm_rdata = mem[bus.dm_addr];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Reference model: byte-address arithmetic over a word array.
  task automatic model(input op_e op, input logic [31:0] addr, input logic [31:0] wd,
                       output exp_t e);
    int unsigned idx, off, size;
    longint      v, mask, full;
    logic [31:0] w;
    idx  = (addr >> 2) % DEPTH;
    off  = addr % 4;
    size = (op == OP_LW || op == OP_SW) ? 4 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
    full = longint'(1) << (8 * size);
    w    = ref_mem[idx];
    e.widx = idx; e.rdata = '0; e.err = 1'b0; e.nwr = 0; e.acc_cyc = 0;
    if (off % size != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (op == OP_SW || op == OP_SH || op == OP_SB) begin
      mask = (full - 1) << (8 * off);
      v = (longint'(w) & ~mask) | ((longint'(wd) << (8 * off)) & mask);
      ref_mem[idx] = v[31:0];
      e.nwr = 1;
      e.lat = (size == 4) ? 2 : 3;
    end else begin
      v = (longint'(w) >> (8 * off)) % full;
      if ((op == OP_LH || op == OP_LB) && v >= (full / 2)) v = v - full;
      e.rdata = v[31:0];
      e.lat = 2;
    end
    e.word = ref_mem[idx];
  endtask

  task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: actual=no_accept required=accept op=%0d", op);
      bus.req_valid = 1'b0;
      return;
    end
    model(op, addr, wd, e);
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every response against the scoreboard head.
  initial begin
    bit          seen;
    bit          exp_idle;
    int          wr_cnt;
    logic [31:0] hold_d;
    logic        hold_e;
    exp_t        e;
    seen = 1'b0; exp_idle = 1'b0; wr_cnt = 0; hold_d = '0; hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0; exp_idle = 1'b0; wr_cnt = 0;
        continue;
      end
      if (exp_idle) begin
        check("idle_after_rsp.req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("idle_after_rsp.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        exp_idle = 1'b0;
      end
      if (bus.dm_we === 1'b1) begin
        wr_cnt++;
        if (sbq.size() > 0) check("dm_addr_on_write", {20'd0, bus.dm_addr}, sbq[0].widx);
      end
      if (bus.rsp_valid === 1'b1) begin
        check("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
        if (!seen) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: actual=rsp_valid required=no_response");
          end else begin
            e = sbq.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            check("latency", cyc - e.acc_cyc + 1, e.lat);
            check("write_count", wr_cnt, e.nwr);
            check("mem_word", mem[e.widx], e.word);
          end
          hold_d = bus.rsp_rdata;
          hold_e = bus.rsp_err;
          seen   = 1'b1;
          wr_cnt = 0;
        end else begin
          check("hold_rdata", bus.rsp_rdata, hold_d);
          check("hold_err", {31'd0, bus.rsp_err}, {31'd0, hold_e});
        end
        if (bus.rsp_ready === 1'b1) begin
          seen     = 1'b0;
          exp_idle = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_e         op;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset.rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    check("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset.dm_we",     {31'd0, bus.dm_we},     32'd0);
    check("reset.dm_addr",   {20'd0, bus.dm_addr},   32'd0);
    check("reset.dm_wdata",  bus.dm_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: word store, sub-word loads, RMW stores, misaligned accesses
    issue(OP_SW,  32'h0000_0010, 32'hDEAD_BEEF);
    issue(OP_LW,  32'h0000_0010, 32'h0);
    issue(OP_SW,  32'h0000_0010, 32'h80FF_7F01);
    issue(OP_LB,  32'h0000_0013, 32'h0);
    issue(OP_LBU, 32'h0000_0013, 32'h0);
    issue(OP_LH,  32'h0000_0012, 32'h0);
    issue(OP_LHU, 32'h0000_0010, 32'h0);
    issue(OP_LW,  32'h0000_0010, 32'h0);
    issue(OP_SB,  32'h0000_0011, 32'h0000_00AA);
    issue(OP_SH,  32'h0000_0012, 32'h0000_1234);
    issue(OP_LW,  32'h0000_0010, 32'h0);
    issue(OP_LW,  32'h0000_0002, 32'h0);
    issue(OP_SH,  32'h0000_0003, 32'hFFFF_FFFF);
    issue(OP_LH,  32'h0000_0001, 32'h0);
    issue(OP_SW,  32'hFFFF_C014, 32'h1357_9BDF);
    issue(OP_LW,  32'h0000_0014, 32'h0);

    // Response stalled in RESP while the next request waits
    drain();
    rdy_mode = 2;
    issue(OP_LHU, 32'h0000_0012, 32'h0);
    fork
      issue(OP_LBU, 32'h0000_0010, 32'h0);
      begin
        repeat (8) @(posedge clk);
        rdy_mode = 1;
      end
    join

    // Randomized mix with random response back-pressure
    drain();
    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      op = op_e'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      a  = a | ($urandom << 14);
      issue(op, a, $urandom);
    end
    rdy_mode = 1;
    drain();

    // Reset while an SB sits in WRITE: the pending write is lost
    bus.req_op    = OP_SB;
    bus.req_addr  = 32'h0000_0011;
    bus.req_wdata = 32'h0000_0055;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("rstwr.accept_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rstwr.exec_we", {31'd0, bus.dm_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rstwr.write_we", {31'd0, bus.dm_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwr.we_drop", {31'd0, bus.dm_we}, 32'd0);
    @(negedge clk);
    check("rstwr.mem_kept", mem[4], ref_mem[4]);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstwr.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstwr.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rstwr.mem_after", mem[4], ref_mem[4]);
    @(posedge clk);
    #1;
    issue(OP_LW, 32'h0000_0010, 32'h0);
    issue(OP_SB, 32'h0000_0013, 32'h0000_0066);
    issue(OP_LW, 32'h0000_0010, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side initiator for the word-wide data memory. Accepts one load/store per handshake from the MEM stage.
- Word-addresses the memory and sign/zero-extends sub-word loads.
- Performs read-modify-write for byte/halfword stores.
- Flags misaligned accesses. Sits between the MEM pipeline stage and the data memory, which has an asynchronous read port and writes on the falling clock edge.

Parameters:
ADDR_W, 12, data-memory word-address width; memory depth is 2^ADDR_W words.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
req_addr  in  32  byte address.
req_wdata  in  32  store data; sub-word stores use the low bits.
rsp_valid  out  1  response present.
rsp_ready  in  1  pipeline accepts the response.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned access.
dm_addr  out  ADDR_W  memory word address.
dm_wdata  out  32  memory write data.
dm_we  out  1  memory write enable.
dm_rdata  in  32  memory combinational read data.

Behaviour:
- Reset is asynchronous, active-low, on clk. Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_we=0, dm_addr=0, dm_wdata=0.
- dm_we is decoded from the state register only, so it is stable for the whole cycle, including the falling edge.
- Address mapping:
  - dm_addr = latched addr[ADDR_W+1:2].
  - addr[31:ADDR_W+2] are ignored; the address wraps.
  - Little-endian lanes: byte n occupies bits [8n+7:8n]; halfword h occupies [16h+15:16h].
- Misalignment rules:
  - LW/SW are misaligned if addr[1:0]!=0.
  - LH/LHU/SH are misaligned if addr[0]!=0.
  - Byte accesses are never misaligned.
- FSM states: IDLE, EXEC, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata.
  - If misaligned, go to RESP with rsp_err=1, rsp_rdata=0; no memory access occurs.
  - Otherwise go to EXEC.
- EXEC:
  - dm_addr is driven with the latched word address.
  - Loads: at the rising edge, register the selected lane of dm_rdata into rsp_rdata. LH/LB sign-extend; LHU/LBU zero-extend; LW passes the full word. Go to RESP.
  - SW: dm_we=1, dm_wdata=latched wdata. Go to RESP.
  - SH/SB: dm_we=0. Register dm_rdata with the target lane replaced by wdata[15:0] or wdata[7:0] into the merge register. Go to WRITE.
- WRITE: dm_we=1, dm_wdata=merge register, dm_addr unchanged. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - req_ready=0 in every state other than IDLE; there is no overlap.
- Latency from accept edge to rsp_valid:
  - Loads and SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Errors: 1 cycle.
- rsp_ready held high returns the unit to IDLE on the cycle after rsp_valid first rises.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and drops dm_we.
  - A pending RMW write is discarded; memory keeps its old word.
  - Any response in RESP is lost.
- Only one memory write occurs per store; loads never assert dm_we.

Decomposition:
- Package mau_pkg holds:
  - op encodings (OP_LW … OP_SB);
  - FSM state encoding;
  - helper functions is_store(op) and is_misaligned(op, addr[1:0]).
- One combinational sub-module, mau_byte_lane, performs both load-lane extraction/extension (op, offset, word in → 32-bit out) and store-lane merge (op, offset, old word, wdata in → merged word out).

Test Plan:
- Reset then SW addr 0x0000_0010 data 0xDEADBEEF → dm_we high for exactly 1 cycle with dm_addr=4; rsp_valid 2 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Word 4 = 0x80FF7F01: LB addr 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80FF; LHU 0x10 → 0x00007F01; LW 0x10 → 0x80FF7F01.
- SB addr 0x11 data 0x000000AA on word 0x80FF7F01 → one write of 0x80FFAA01; SH addr 0x12 data 0x1234 → word becomes 0x1234AA01; rsp_valid 3 cycles after accept.
- LW 0x0002, SH 0x0003, LH 0x0001 → rsp_err=1 and rsp_rdata=0 one cycle after accept; dm_we never asserted; memory unchanged.
- rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err are stable; req_ready stays 0 and a new req_valid is not accepted.
- Assert rst_n low during WRITE of an SB → dm_we falls immediately and the target word is unchanged; after release, req_ready=1 and rsp_valid=0.
